// File: rtl/idex_if.sv
// ID/EX boundary bundle: decode-side handshake, execute-side handshake and flush.
// A transfer happens on a rising edge where valid & ready are both high; valid
// and payload must stay stable until that edge, and ready never depends on valid.
interface idex_if #(
  parameter int XLEN = 32,
  parameter int PW   = 5*XLEN+20
);
  logic          flush;
  logic          id_valid;
  logic          id_ready;
  logic [PW-1:0] id_payload;
  logic          ex_valid;
  logic          ex_ready;
  logic [PW-1:0] ex_payload;

  modport master (
    output flush, id_valid, id_payload, ex_ready,
    input  id_ready, ex_valid, ex_payload
  );

  modport slave (
    input  flush, id_valid, id_payload, ex_ready,
    output id_ready, ex_valid, ex_payload
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with optional two-entry skid buffer, flush and
// control squashing on bubbles; occupancy mirrors the FSM state register.
module idex_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16,
  parameter int PW    = 5*XLEN+20
) (
  input  logic             clk,
  input  logic             rst_n,
  idex_if.slave            bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic          ready_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] second_q;
  logic          ex_valid;
  logic          accept;
  logic          consume;

  assign ex_valid  = (state != EMPTY);
  assign occupancy = state;
  assign accept    = bus.id_valid & bus.id_ready;
  assign consume   = ex_valid & bus.ex_ready;

  // Skid mode decodes ready from a register only, cutting the ex_ready -> id_ready path.
  if (SKID != 0) begin : g_skid
    assign bus.id_ready = ready_q;
  end else begin : g_single
    assign bus.id_ready = !ex_valid | bus.ex_ready;
  end

  assign bus.ex_valid   = ex_valid;
  assign bus.ex_payload = {head_q[PW-1:7], ex_valid ? head_q[6:0] : 7'd0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else if (bus.flush) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state <= ONE;
          ready_q <= 1'b1;
        end
        ONE: begin
          if (accept && !consume) begin
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (consume && !accept) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (consume) begin
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Payload storage carries no reset; validity lives entirely in the state register.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush) begin
      if (accept && (state == EMPTY || consume)) begin
        head_q <= bus.id_payload;
      end else if (state == FULL && consume) begin
        head_q <= second_q;
      end
      if (accept && state == ONE && !consume) begin
        second_q <= bus.id_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (ex_valid && !bus.ex_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_idex_stage.sv
// Drives a skid-buffered stage and a single-register stage (2-bit stall counter)
// with shared stimulus and checks both against FIFO reference models.
module tb_idex_stage;
  localparam int XLEN  = 32;
  localparam int PW    = 5*XLEN+20;
  localparam int CNT_A = 16;
  localparam int CNT_B = 2;
  localparam int MAX_A = (1 << CNT_A) - 1;
  localparam int MAX_B = (1 << CNT_B) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0;
  logic          ex_ready = 1'b0;
  logic          flush    = 1'b0;
  logic [PW-1:0] id_payload = '0;

  idex_if #(.XLEN(XLEN)) bus_a ();
  idex_if #(.XLEN(XLEN)) bus_b ();

  assign bus_a.id_valid   = id_valid;
  assign bus_a.id_payload = id_payload;
  assign bus_a.ex_ready   = ex_ready;
  assign bus_a.flush      = flush;
  assign bus_b.id_valid   = id_valid;
  assign bus_b.id_payload = id_payload;
  assign bus_b.ex_ready   = ex_ready;
  assign bus_b.flush      = flush;

  logic [1:0]       occ_a, occ_b;
  logic [CNT_A-1:0] stall_a;
  logic [CNT_B-1:0] stall_b;

  idex_stage #(.XLEN(XLEN), .SKID(1), .CNT_W(CNT_A)) u_skid (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .occupancy(occ_a), .stall_cnt(stall_a)
  );

  idex_stage #(.XLEN(XLEN), .SKID(0), .CNT_W(CNT_B)) u_single (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .occupancy(occ_b), .stall_cnt(stall_b)
  );

  // scoreboard / reference models
  logic [PW-1:0] exp_q_a[$];
  logic [PW-1:0] exp_q_b[$];
  int exp_stall_a = 0;
  int exp_stall_b = 0;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mk_payload(input logic [XLEN-1:0] pc, input logic [6:0] ctl);
    logic [PW-1:0] p;
    p = rand_payload();
    p[PW-1 -: XLEN] = pc;
    p[6:0] = ctl;
    return p;
  endfunction

  task automatic verify_and_model();
    logic v_a, r_a, v_b, r_b;
    v_a = (exp_q_a.size() != 0);
    r_a = (exp_q_a.size() < 2);
    v_b = (exp_q_b.size() != 0);
    r_b = (exp_q_b.size() == 0) || ex_ready;

    chk("a_id_ready",  PW'(bus_a.id_ready), PW'(r_a));
    chk("a_ex_valid",  PW'(bus_a.ex_valid), PW'(v_a));
    chk("a_occupancy", PW'(occ_a), PW'(exp_q_a.size()));
    chk("a_stall_cnt", PW'(stall_a), PW'(exp_stall_a));
    if (v_a) chk("a_ex_payload", bus_a.ex_payload, exp_q_a[0]);
    else     chk("a_bubble_ctl", PW'(bus_a.ex_payload[6:0]), '0);

    chk("b_id_ready",  PW'(bus_b.id_ready), PW'(r_b));
    chk("b_ex_valid",  PW'(bus_b.ex_valid), PW'(v_b));
    chk("b_occupancy", PW'(occ_b), PW'(exp_q_b.size()));
    chk("b_stall_cnt", PW'(stall_b), PW'(exp_stall_b));
    if (v_b) chk("b_ex_payload", bus_b.ex_payload, exp_q_b[0]);
    else     chk("b_bubble_ctl", PW'(bus_b.ex_payload[6:0]), '0);

    if (!rst_n) begin
      exp_q_a.delete();
      exp_q_b.delete();
      exp_stall_a = 0;
      exp_stall_b = 0;
    end else begin
      if (v_a && !ex_ready && exp_stall_a < MAX_A) exp_stall_a++;
      if (v_a && ex_ready) void'(exp_q_a.pop_front());
      if (flush) exp_q_a.delete();
      else if (id_valid && r_a) exp_q_a.push_back(id_payload);

      if (v_b && !ex_ready && exp_stall_b < MAX_B) exp_stall_b++;
      if (v_b && ex_ready) void'(exp_q_b.pop_front());
      if (flush) exp_q_b.delete();
      else if (id_valid && r_b) exp_q_b.push_back(id_payload);
    end
  endtask

  // driver: one clock cycle of stimulus, then check and advance the models
  task automatic cycle(input logic v, input logic [PW-1:0] p, input logic r,
                       input logic f, input logic rn);
    @(posedge clk);
    #1;
    id_valid   = v;
    id_payload = p;
    ex_ready   = r;
    flush      = f;
    rst_n      = rn;
    #1;
    verify_and_model();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // reset state, then streaming
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, mk_payload(32'h100 + 32'(4*i), 7'h01), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // backpressure then release
    for (int i = 0; i < 3; i++) cycle(1'b1, mk_payload(32'h200 + 32'(4*i), 7'h03), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // flush with a branch and a store held
    cycle(1'b1, mk_payload(32'h300, 7'h40), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, mk_payload(32'h304, 7'h20), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, mk_payload(32'h308, 7'h60), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // ex_ready toggling under continuous input
    for (int i = 0; i < 6; i++)
      cycle(1'b1, mk_payload(32'h400 + 32'(4*i), 7'h05), (i % 2 == 0) || (i == 5), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // reset in the middle of a stalled stream
    for (int i = 0; i < 7; i++) cycle(1'b1, mk_payload(32'h500 + 32'(4*i), 7'h7f), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, mk_payload(32'h600, 7'h7f), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    // stall counter saturation on the 2-bit instance
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, mk_payload(32'h700, 7'h01), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_payload(),
            1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 49) != 0));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
